vga_dtg_world: RTL and testbench

- Display timing generator and world-map address stage for the VGA path.
- Generates 640x480@60 Hz sync timing from a pixel-rate enable.
- Produces the 14-bit address for the rojobot 128x128 world-map RAM.
- Delays video_on/hsync/vsync by the map RAM read latency so they line up with world_pixel at the colorizer input.

---
 rtl/vga_dtg_world.sv | 136 +++++++++++++
 tb/tb_vga_dtg_world.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_dtg_world.sv
// 640x480@60 display timing generator with rojobot world-map address stage.
// Syncs and video_on are delayed PIPE_DLY pixel ticks to match the map RAM read latency.
module vga_dtg_world #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_DLY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_column,
  output logic [9:0]  pixel_row,
  output logic [13:0] world_addr,
  output logic        in_world,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic       SYNC_IDLE = ~SYNC_ACTIVE;

  // Sync fields are held at pin level so the outputs come straight off flops.
  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } tmg_t;

  localparam tmg_t TMG_IDLE = '{hs: SYNC_IDLE, vs: SYNC_IDLE, von: 1'b0};

  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        frame_start_q, frame_start_d;
  logic        in_world_q, in_world_d;
  logic [13:0] world_addr_q, world_addr_d;
  tmg_t        nx_raw;
  tmg_t        dl_q [PIPE_DLY+1];
  tmg_t        dl_d [PIPE_DLY+1];

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 10'd0;
        if (vcount_q == V_LAST) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // Decode is taken from the next counts; stage 0 therefore lines up with the counters.
  always_comb begin
    nx_raw.hs  = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_ACTIVE : SYNC_IDLE;
    nx_raw.vs  = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_ACTIVE : SYNC_IDLE;
    nx_raw.von = (hcount_d < H_VIS) && (vcount_d < V_VIS);
  end

  always_comb begin
    dl_d = dl_q;
    if (pix_en) begin
      dl_d[0] = nx_raw;
      for (int k = 1; k <= PIPE_DLY; k++) begin
        dl_d[k] = dl_q[k-1];
      end
    end
  end

  // World map covers columns 0..511 and rows 0..479, four screen pixels per map cell.
  always_comb begin
    in_world_d   = in_world_q;
    world_addr_d = world_addr_q;
    if (pix_en) begin
      in_world_d   = (hcount_d < 10'd512) && (vcount_d < 10'd480);
      world_addr_d = in_world_d ? {vcount_d[8:2], hcount_d[8:2]} : 14'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      frame_start_q <= 1'b0;
      in_world_q    <= 1'b0;
      world_addr_q  <= 14'd0;
      for (int k = 0; k <= PIPE_DLY; k++) begin
        dl_q[k] <= TMG_IDLE;
      end
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      in_world_q    <= in_world_d;
      world_addr_q  <= world_addr_d;
      for (int k = 0; k <= PIPE_DLY; k++) begin
        dl_q[k] <= dl_d[k];
      end
    end
  end

  assign hsync        = dl_q[PIPE_DLY].hs;
  assign vsync        = dl_q[PIPE_DLY].vs;
  assign video_on     = dl_q[PIPE_DLY].von;
  assign pixel_column = hcount_q;
  assign pixel_row    = vcount_q;
  assign world_addr   = world_addr_q;
  assign in_world     = in_world_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_dtg_world.sv
// Randomized pixel-enable bench for vga_dtg_world against a linear-position frame model.
// A short vertical timing keeps whole frames, wraps and vsync within a small cycle count.
module tb_vga_dtg_world;

  localparam int   H_ACTIVE = 640;
  localparam int   H_FP     = 16;
  localparam int   H_SYNC   = 96;
  localparam int   H_BP     = 48;
  localparam int   V_ACTIVE = 8;
  localparam int   V_FP     = 2;
  localparam int   V_SYNC   = 2;
  localparam int   V_BP     = 3;
  localparam logic SA       = 1'b0;
  localparam int   DLY      = 1;

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  // Clock and reset
  logic clock = 1'b0;
  logic reset;
  logic pix_en;
  always #5 clock = ~clock;

  logic        hsync, vsync, video_on, in_world, frame_start;
  logic [9:0]  pixel_column, pixel_row;
  logic [13:0] world_addr;

  vga_dtg_world #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_ACTIVE(SA), .PIPE_DLY(DLY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pix_en(pix_en),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .pixel_column(pixel_column),
    .pixel_row(pixel_row),
    .world_addr(world_addr),
    .in_world(in_world),
    .frame_start(frame_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position within the frame as one linear index; history of visited positions.
  int p;
  int hist[$];
  bit ticked;
  bit fs;

  task automatic model_reset();
    p = 0;
    hist.delete();
    ticked = 1'b0;
    fs = 1'b0;
  endtask

  task automatic model_tick();
    p = (p + 1) % FRAME;
    hist.push_back(p);
    if (hist.size() > 8) void'(hist.pop_front());
    ticked = 1'b1;
    fs = (p == 0);
  endtask

  task automatic check_all();
    int h, v, d, dh, dv;
    logic e_hs, e_vs, e_von, e_iw;
    logic [31:0] e_addr;
    h = p % HT;
    v = p / HT;
    d = (hist.size() > DLY) ? hist[hist.size() - 1 - DLY] : -1;
    if (d < 0) begin
      e_hs = ~SA; e_vs = ~SA; e_von = 1'b0;
    end else begin
      dh = d % HT;
      dv = d / HT;
      e_hs  = (dh >= H_ACTIVE + H_FP && dh < H_ACTIVE + H_FP + H_SYNC) ? SA : ~SA;
      e_vs  = (dv >= V_ACTIVE + V_FP && dv < V_ACTIVE + V_FP + V_SYNC) ? SA : ~SA;
      e_von = (dh < H_ACTIVE) && (dv < V_ACTIVE);
    end
    e_iw   = ticked && (h < 512) && (v < 480);
    e_addr = e_iw ? 32'(((v / 4) % 128) * 128 + ((h / 4) % 128)) : 32'd0;
    check_val("pixel_column", 32'(pixel_column), 32'(h));
    check_val("pixel_row", 32'(pixel_row), 32'(v));
    check_val("hsync", 32'(hsync), 32'(e_hs));
    check_val("vsync", 32'(vsync), 32'(e_vs));
    check_val("video_on", 32'(video_on), 32'(e_von));
    check_val("in_world", 32'(in_world), 32'(e_iw));
    check_val("world_addr", 32'(world_addr), e_addr);
    check_val("frame_start", 32'(frame_start), 32'(fs));
  endtask

  // Driver: one clock with the given enable, model follows the edge, check at negedge.
  task automatic run_clk(input bit en);
    pix_en = en;
    @(posedge clock);
    if (en) model_tick();
    else fs = 1'b0;
    @(negedge clock);
    check_all();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) run_clk($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int guard;
    reset  = 1'b1;
    pix_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all();
    reset = 1'b0;
    run_clk(1'b0);
    run_clk(1'b0);
    repeat (4) run_clk(1'b1);
    check_val("four_ticks_col", 32'(pixel_column), 32'd4);

    run_random(3000);

    // Asynchronous reset mid-frame: outputs must clear before the next edge.
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    check_all();
    reset = 1'b0;
    repeat (4) run_clk(1'b1);

    // Stall at the last visible column.
    guard = 0;
    while (p % HT != H_ACTIVE - 1 && guard < 2 * HT) begin
      run_clk(1'b1);
      guard++;
    end
    check_val("reach_col_639", 32'(pixel_column), 32'(H_ACTIVE - 1));
    repeat (50) run_clk(1'b0);
    repeat (3) run_clk(1'b1);

    run_random(28000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
